// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: CH-way N-bit channel mux, direct or round-robin select, registered valid/ready output
module sel_pipe_mux #(
  parameter int N     = 8,
  parameter int CH    = 6,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*N-1:0]   in_data,
  input  logic [CH-1:0]     in_valid,
  output logic [CH-1:0]     in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  select,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch,
  output logic              sel_err
);
  logic [N-1:0]     out_data_q, out_data_d, g_data;
  logic [SEL_W-1:0] out_ch_q, out_ch_d, ptr_q, ptr_d, rr_g, g;
  logic             out_valid_q, out_valid_d, sel_err_q, sel_err_d;
  logic             sel_ok, dir_valid, grant_valid, accept, load;

  // Round-robin search: smallest distance after ptr wins, wrapping CH-1 -> 0
  always_comb begin
    rr_g = '0;
    for (int i = CH - 1; i >= 0; i--)
      for (int k = 0; k < CH; k++)
        if (in_valid[k] && (int'(ptr_q) + 1 + i == k || int'(ptr_q) + 1 + i == k + CH)) rr_g = SEL_W'(k);
  end

  // Grant resolution for the active mode, handshake and granted channel data
  always_comb begin
    sel_ok      = int'(select) < CH;
    dir_valid   = 1'b0;
    for (int k = 0; k < CH; k++)
      if (SEL_W'(k) == select) dir_valid = in_valid[k];
    g           = mode ? rr_g : select;
    grant_valid = mode ? |in_valid : dir_valid;
    accept      = !out_valid_q || out_ready;
    load        = accept && grant_valid;
    in_ready    = '0;
    g_data      = '0;
    for (int k = 0; k < CH; k++) begin
      in_ready[k] = load && SEL_W'(k) == g;
      if (SEL_W'(k) == g) g_data = in_data[k*N +: N];
    end
  end

  // Next state: load replaces the beat, an idle accept empties it, a stall holds everything
  always_comb begin
    out_data_d  = load ? g_data : out_data_q;
    out_ch_d    = load ? g : out_ch_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    ptr_d       = (load && mode) ? g : ptr_q;
    sel_err_d   = !mode && !sel_ok;
  end

  // State registers; ptr resets to CH-1 so channel 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ptr_q       <= SEL_W'(CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_sel_pipe_mux.sv
// tb_sel_pipe_mux: directed scenarios plus randomized run against a behavioural model
module tb_sel_pipe_mux;
  localparam int N = 8, CH = 6, SEL_W = 3;
  logic clk = 0, rst_n = 0;
  logic [CH*N-1:0] in_data = '0;
  logic [CH-1:0] in_valid = '0, in_ready;
  logic mode = 0, out_valid, out_ready = 0, sel_err;
  logic [SEL_W-1:0] select = '0, out_ch;
  logic [N-1:0] out_data;
  int n_cmp = 0, n_fail = 0;

  sel_pipe_mux #(.N(N), .CH(CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .select(select), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .sel_err(sel_err));

  always #5 clk = ~clk;

  task automatic drive(input logic m, input logic [SEL_W-1:0] s, input logic [CH-1:0] v, input logic r);
    mode = m; select = s; in_valid = v; out_ready = r;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset;
    in_valid = '0; rst_n = 0; #2; rst_n = 1;
  endtask

  task automatic test_reset;
    in_valid = '1; #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_cmp++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", sel_err); end
    in_valid = '0; @(negedge clk); rst_n = 1; tick;
  endtask

  task automatic test_direct;
    for (int k = 0; k < CH; k++) in_data[k*N +: N] = N'($urandom);
    in_data[2*N +: N] = 8'hA5;
    drive(0, 3'd2, 6'b000100, 1); #1;
    n_cmp++; if (in_ready !== 6'b000100) begin n_fail++; $display("FAIL direct_ready got=%b exp=000100", in_ready); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd2) begin n_fail++; $display("FAIL direct_out got=%b/%h/%0d exp=1/a5/2", out_valid, out_data, out_ch); end
    in_valid = '0; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL direct_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sel_err;
    drive(0, 3'd6, '1, 1); #1;
    n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL err_ready got=%b exp=000000", in_ready); end
    tick;
    n_cmp++; if (sel_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL err_flag got=%b/%b exp=1/0", sel_err, out_valid); end
    select = 3'd7; tick;
    n_cmp++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL err_sel7 got=%b exp=1", sel_err); end
    select = 3'd1; #1;
    n_cmp++; if (in_ready !== 6'b000010) begin n_fail++; $display("FAIL err_recover_ready got=%b exp=000010", in_ready); end
    tick;
    n_cmp++; if (sel_err !== 1'b0 || out_ch !== 3'd1) begin n_fail++; $display("FAIL err_clear got=%b/%0d exp=0/1", sel_err, out_ch); end
    in_valid = '0; tick;
  endtask

  task automatic test_rr;
    logic [N-1:0] d [CH];
    int seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    for (int k = 0; k < CH; k++) begin d[k] = N'($urandom); in_data[k*N +: N] = d[k]; end
    drive(1, 3'd7, '1, 1);
    for (int i = 0; i < 8; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== SEL_W'(seq[i]) || out_data !== d[seq[i]] || sel_err !== 1'b0)
        begin n_fail++; $display("FAIL rr_seq[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_ch, out_data, seq[i], d[seq[i]]); end
    end
    in_valid = '0; tick;
  endtask

  task automatic test_stall;
    logic [N-1:0] d1, d5;
    pulse_reset;
    d1 = N'($urandom); d5 = N'($urandom);
    in_data[1*N +: N] = d1; in_data[5*N +: N] = d5;
    drive(1, 3'd0, 6'b100010, 1); tick;
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd1 || out_data !== d1) begin n_fail++; $display("FAIL stall_first got=%b/%0d/%h exp=1/1/%h", out_valid, out_ch, out_data, d1); end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b exp=000000", i, in_ready); end
      in_data[1*N +: N] = N'($urandom);
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd1 || out_data !== d1) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%0d/%h exp=1/1/%h", i, out_valid, out_ch, out_data, d1); end
    end
    in_data[1*N +: N] = d1; out_ready = 1; #1;
    n_cmp++; if (in_ready !== 6'b100000) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=100000", in_ready); end
    tick;
    n_cmp++; if (out_ch !== 3'd5 || out_data !== d5) begin n_fail++; $display("FAIL stall_next got=%0d/%h exp=5/%h", out_ch, out_data, d5); end
    tick;
    n_cmp++; if (out_ch !== 3'd1 || out_data !== d1) begin n_fail++; $display("FAIL stall_wrap got=%0d/%h exp=1/%h", out_ch, out_data, d1); end
    in_valid = '0; tick;
  endtask

  task automatic test_back_to_back;
    drive(0, 3'd3, 6'b001000, 1);
    in_data[3*N +: N] = 8'd1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== N'(i)) begin n_fail++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, N'(i)); end
      in_data[3*N +: N] = N'(i + 1);
    end
    in_valid = '0; tick;
  endtask

  task automatic test_async_reset;
    pulse_reset;
    drive(1, 3'd0, 6'b001000, 1); tick;
    out_ready = 0; tick;
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd3) begin n_fail++; $display("FAIL areset_pre got=%b/%0d exp=1/3", out_valid, out_ch); end
    #2 rst_n = 0; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== '0) begin n_fail++; $display("FAIL areset_now got=%b/%0d/%h exp=0/0/00", out_valid, out_ch, out_data); end
    #1 rst_n = 1;
    drive(1, 3'd0, '1, 1); tick;
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd0) begin n_fail++; $display("FAIL areset_first_grant got=%b/%0d exp=1/0", out_valid, out_ch); end
    in_valid = '0; tick;
  endtask

  task automatic test_random;
    int m_ptr = CH - 1, m_ch = 0, g;
    logic [N-1:0] m_data = '0;
    logic m_valid = 0, m_err = 0, gv, acc;
    logic [CH-1:0] exp_ready;
    pulse_reset;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < CH; k++) in_data[k*N +: N] = N'($urandom);
      drive(1'($urandom), SEL_W'($urandom_range(0, 7)), CH'($urandom), $urandom_range(0, 3) != 0);
      acc = !m_valid || out_ready;
      g = 0; gv = 0;
      if (mode) begin
        for (int off = CH; off >= 1; off--)
          if (in_valid[(m_ptr + off) % CH]) begin g = (m_ptr + off) % CH; gv = 1; end
      end else if (int'(select) < CH) begin
        g = int'(select); gv = in_valid[g];
      end
      exp_ready = (acc && gv) ? CH'(1) << g : '0;
      #1;
      n_cmp++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, in_ready, exp_ready); end
      if (acc && gv) begin
        m_data = in_data[g*N +: N]; m_ch = g; m_valid = 1;
        if (mode) m_ptr = g;
      end else if (acc) m_valid = 0;
      m_err = !mode && int'(select) >= CH;
      tick;
      n_cmp++; if (out_valid !== m_valid || out_ch !== SEL_W'(m_ch) || out_data !== m_data || sel_err !== m_err)
        begin n_fail++; $display("FAIL rand_out[%0d] got=%b/%0d/%h/%b exp=%b/%0d/%h/%b", c, out_valid, out_ch, out_data, sel_err, m_valid, m_ch, m_data, m_err); end
    end
    in_valid = '0; tick;
  endtask

  initial begin
    test_reset;
    test_direct;
    test_sel_err;
    test_rr;
    test_stall;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sel_pipe_mux.md
Name: sel_pipe_mux

Overview:
- Parametrised successor to the fixed 6-way ALU result selector: CH-way, N-bit channel multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes: direct (external select, as the ALU op decode drives it) and round-robin (fair arbitration among requesting channels).
- An out-of-range select raises an error flag and forwards nothing. The output never floats.
- Sits between the ALU functional units (add, logic, shift, …) and the result register/writeback path.

Parameters:
- N, 8, data width of each channel and of the output.
- CH, 6, number of input channels; legal range 2..2**SEL_W.
- SEL_W, 3, width of select and out_ch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CH*N  flattened channel data; channel k occupies bits [k*N+N-1 : k*N].
- in_valid  input  CH  per-channel data valid.
- in_ready  output  CH  per-channel accept; combinational.
- mode  input  1  0 = direct select, 1 = round-robin.
- select  input  SEL_W  channel index used when mode = 0.
- out_data  output  N  registered selected data.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accept.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- sel_err  output  1  registered; high when the previous cycle had mode = 0 and select >= CH.

Behaviour:
- Reset (async on rst_n low, takes effect immediately):
  - out_valid = 0, out_data = 0, out_ch = 0, sel_err = 0.
  - Round-robin pointer ptr = CH-1, so channel 0 has first priority.
- Transfer rules:
  - An input transfer on channel k occurs in a cycle where in_valid[k] && in_ready[k].
  - An output transfer occurs where out_valid && out_ready.
  - Define accept = !out_valid || out_ready. This gives full throughput, one beat per cycle, with no bubble.
  - in_ready is one-hot or zero. in_ready[g] = accept && grant_valid, where g is the granted channel. All other bits are 0.
- Direct mode (mode = 0):
  - If select < CH: g = select and grant_valid = in_valid[select].
  - If select >= CH: grant_valid = 0, all in_ready = 0, no beat is loaded, and sel_err is set to 1 on the next edge.
  - sel_err clears on the next edge after any cycle without the error condition.
- Round-robin mode (mode = 1):
  - Search from ptr+1 upward with wrap at CH-1 -> 0. Grant the first k with in_valid[k]=1.
  - grant_valid = |in_valid.
  - ptr updates to g only on an input transfer. It is unchanged when the output is stalled or no channel is valid.
  - sel_err is forced to 0 on the next edge; select is ignored.
- Output register, on an input transfer:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
- When accept is high but no input transfer occurs: out_valid <= 0, and out_data/out_ch hold their old values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold stable, and all in_ready = 0.
- Latency: one cycle from input transfer to out_valid.
- Mode or select changes:
  - Take effect combinationally for the current cycle's grant.
  - ptr is retained across mode switches.
  - A beat already in the output register is never altered.
- Simultaneous output drain and new load in the same cycle: the new beat replaces the old one, and out_valid stays 1.
- in_valid dropping without a transfer is tolerated, with no protocol error. The block is not required to check producer stability.
- CH < 2**SEL_W: select values CH..2**SEL_W-1 are the error range. With CH = 2**SEL_W the error range is empty and sel_err is always 0.

Test Plan:
- Reset, then mode=0, select=2, in_valid=6'b000100, ch2=8'hA5, out_ready=1 -> in_ready=6'b000100; next cycle out_valid=1, out_data=A5, out_ch=2; following cycle out_valid=0.
- mode=0, select=6 (CH=6), all in_valid=1 -> in_ready=0; next cycle sel_err=1, out_valid=0; select=1 -> sel_err=0 one cycle later.
- mode=1, all six valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,4,5,0,1, each with its channel's data.
- mode=1, in_valid=6'b100010, out_ready=0 after first load -> out_ch=1 held, data stable, in_ready=0 while stalled; after out_ready=1 the next beat is out_ch=5, then 1.
- Back-to-back streaming: mode=0, select=3, ch3 valid every cycle with values 1,2,3,4, out_ready=1 -> out_valid continuous, out_data 1,2,3,4 on consecutive cycles.
- Assert rst_n=0 mid-stall with out_valid=1, ptr=3 -> out_valid=0 immediately without a clock edge; after release, mode=1 with all valid -> first grant is channel 0.
